// File: rtl/ibex_rf_wport_ctrl.sv
// Write-port controller for the flip-flop register file: shares the single write port
// between architectural writeback (with zero-precharge for secure data) and a scrub engine.
module ibex_rf_wport_ctrl #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wb_req_i,
    input  logic                 wb_secure_i,
    input  logic [4:0]           wb_addr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 wb_ready_o,
    input  logic                 scrub_req_i,
    output logic                 scrub_busy_o,
    output logic                 scrub_done_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_first_cycle_o,
    output logic                 err_o
);

    localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32;
    localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRECHARGE = 2'd1;
    localparam logic [1:0] SCRUB     = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  pend_q, pend_d;
    logic [4:0]            addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d          = state_q;
        pend_d           = pend_q;
        addr_d           = addr_q;
        cnt_d            = cnt_q;
        done_d           = 1'b0;
        rf_we_o          = 1'b0;
        rf_waddr_o       = 5'd0;
        rf_wdata_o       = '0;
        rf_first_cycle_o = 1'b0;
        wb_ready_o       = 1'b0;
        err_o            = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    cnt_d   = ADDR_WIDTH'(1);
                    state_d = SCRUB;
                end else if (wb_req_i && wb_secure_i && (wb_addr_i != 5'd0)) begin
                    rf_we_o          = 1'b1;
                    rf_waddr_o       = wb_addr_i;
                    rf_first_cycle_o = 1'b1;
                    addr_d           = wb_addr_i;
                    state_d          = PRECHARGE;
                end else begin
                    rf_we_o    = wb_req_i;
                    rf_waddr_o = wb_addr_i;
                    rf_wdata_o = wb_wdata_i;
                    wb_ready_o = 1'b1;
                end
            end
            PRECHARGE: begin
                state_d = IDLE;
                // A dropped or retargeted request leaves the precharged register at zero.
                if (wb_req_i && (wb_addr_i == addr_q)) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = addr_q;
                    rf_wdata_o = wb_wdata_i;
                    wb_ready_o = 1'b1;
                end else begin
                    err_o = 1'b1;
                end
            end
            SCRUB: begin
                rf_we_o          = 1'b1;
                rf_waddr_o       = 5'(cnt_q);
                rf_first_cycle_o = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (scrub_req_i && (state_q != SCRUB)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            addr_q  <= 5'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign scrub_busy_o = pend_q | (state_q == SCRUB);
    assign scrub_done_o = done_q;

endmodule

// File: tb/tb_ibex_rf_wport_ctrl.sv
// Self-checking bench for ibex_rf_wport_ctrl: a transaction-level model of the write port
// and register file, directed scenarios with literal expectations, then random traffic.
module tb_ibex_rf_wport_ctrl;

    localparam int NUM = 32;

    typedef struct packed {
        int   preAddr;
        int   scrubAddr;
        logic scrubPend;
        logic doneFlag;
    } mdl_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fc;
        logic        rdy;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        wbReq = 1'b0;
    logic        wbSecure = 1'b0;
    logic [4:0]  wbAddr = 5'd0;
    logic [31:0] wbWdata = 32'h0;
    logic        scrubReq = 1'b0;
    logic        wbReady, scrubBusy, scrubDone, rfWe, rfFirst, err;
    logic [4:0]  rfWaddr;
    logic [31:0] rfWdata;

    int total = 0;
    int bad = 0;

    mdl_t        m;
    exp_t        modelOut;
    logic [31:0] rfModel [NUM];
    logic [31:0] rfDut [NUM];
    logic [31:0] saved [NUM];

    ibex_rf_wport_ctrl #(.RV32E(1'b0), .DataWidth(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .wb_req_i        (wbReq),
        .wb_secure_i     (wbSecure),
        .wb_addr_i       (wbAddr),
        .wb_wdata_i      (wbWdata),
        .wb_ready_o      (wbReady),
        .scrub_req_i     (scrubReq),
        .scrub_busy_o    (scrubBusy),
        .scrub_done_o    (scrubDone),
        .rf_we_o         (rfWe),
        .rf_waddr_o      (rfWaddr),
        .rf_wdata_o      (rfWdata),
        .rf_first_cycle_o(rfFirst),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    // Expected port activity this cycle; preAddr/scrubAddr of 0 mean "none" since r0 is never stored.
    function automatic exp_t expectOut(mdl_t s, logic req, logic sec, logic [4:0] addr, logic [31:0] data);
        exp_t e;
        e = '0;
        if (s.scrubAddr != 0) begin
            e.we = 1'b1; e.waddr = 5'(s.scrubAddr); e.fc = 1'b1;
        end else if (s.preAddr != 0) begin
            if (req && int'(addr) == s.preAddr) begin
                e.we = 1'b1; e.waddr = addr; e.wdata = data; e.rdy = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else if (s.scrubPend) begin
            e.we = 1'b0;
        end else if (req && sec && addr != 5'd0) begin
            e.we = 1'b1; e.waddr = addr; e.fc = 1'b1;
        end else begin
            e.we = req; e.waddr = addr; e.wdata = data; e.rdy = 1'b1;
        end
        return e;
    endfunction

    function automatic mdl_t nextModel(mdl_t s, logic req, logic sec, logic [4:0] addr, logic scrub);
        mdl_t n;
        n = s;
        n.doneFlag = (s.scrubAddr == NUM - 1);
        if (s.scrubAddr != 0) begin
            n.scrubAddr = (s.scrubAddr == NUM - 1) ? 0 : s.scrubAddr + 1;
        end else if (s.preAddr != 0) begin
            n.preAddr = 0;
        end else if (s.scrubPend) begin
            n.scrubPend = 1'b0;
            n.scrubAddr = 1;
        end else if (req && sec && addr != 5'd0) begin
            n.preAddr = int'(addr);
        end
        if (scrub && s.scrubAddr == 0) n.scrubPend = 1'b1;
        return n;
    endfunction

    assign modelOut = expectOut(m, wbReq, wbSecure, wbAddr, wbWdata);

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m <= '0;
        end else begin
            m <= nextModel(m, wbReq, wbSecure, wbAddr, scrubReq);
            if (modelOut.we && modelOut.waddr != 5'd0)
                rfModel[modelOut.waddr] <= modelOut.fc ? 32'h0 : modelOut.wdata;
        end
    end

    // Stand-in for the register file, driven by what the DUT actually puts on the port.
    always @(posedge clk) begin
        if (rfWe && rfWaddr != 5'd0)
            rfDut[rfWaddr] <= rfFirst ? 32'h0 : rfWdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("rf_we", 32'(rfWe), 32'(modelOut.we));
        checkOutput("rf_waddr", 32'(rfWaddr), 32'(modelOut.waddr));
        checkOutput("rf_wdata", rfWdata, modelOut.wdata);
        checkOutput("rf_first_cycle", 32'(rfFirst), 32'(modelOut.fc));
        checkOutput("wb_ready", 32'(wbReady), 32'(modelOut.rdy));
        checkOutput("err", 32'(err), 32'(modelOut.err));
        checkOutput("scrub_busy", 32'(scrubBusy), 32'(m.scrubPend || m.scrubAddr != 0));
        checkOutput("scrub_done", 32'(scrubDone), 32'(m.doneFlag));
    endtask

    task automatic applyStimulus(input logic req, input logic sec, input logic [4:0] addr,
                                 input logic [31:0] data, input logic scrub);
        @(posedge clk);
        #1;
        wbReq = req; wbSecure = sec; wbAddr = addr; wbWdata = data; scrubReq = scrub;
        #2;
        compareModel();
    endtask

    initial begin
        int lowCnt, scrubWrites, lastAddr, lastIdx, doneIdx, doneCnt, diffs;
        logic found, hold, violate;
        logic [31:0] d, r9Saved;

        #2 rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("reset_wb_ready", 32'(wbReady), 32'd1);
        checkOutput("reset_busy", 32'(scrubBusy), 32'd0);
        checkOutput("reset_we", 32'(rfWe), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        rstN = 1'b1;

        for (int i = 1; i < NUM; i++) applyStimulus(1'b1, 1'b0, 5'(i), $urandom, 1'b0);

        applyStimulus(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("ns_we", 32'(rfWe), 32'd1);
        checkOutput("ns_waddr", 32'(rfWaddr), 32'd5);
        checkOutput("ns_first", 32'(rfFirst), 32'd0);
        checkOutput("ns_ready", 32'(wbReady), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("ns_r5", rfDut[5], 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0);
        checkOutput("sec0_we", 32'(rfWe), 32'd1);
        checkOutput("sec0_first", 32'(rfFirst), 32'd1);
        checkOutput("sec0_ready", 32'(wbReady), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0);
        checkOutput("sec_r7_precharged", rfDut[7], 32'h0);
        checkOutput("sec1_wdata", rfWdata, 32'h12345678);
        checkOutput("sec1_first", 32'(rfFirst), 32'd0);
        checkOutput("sec1_ready", 32'(wbReady), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("sec_r7_data", rfDut[7], 32'h12345678);

        r9Saved = rfDut[9];
        applyStimulus(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0);
        checkOutput("viol_err", 32'(err), 32'd1);
        checkOutput("viol_we", 32'(rfWe), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("viol_err_once", 32'(err), 32'd0);
        checkOutput("viol_r7_zero", rfDut[7], 32'h0);
        checkOutput("viol_r9_kept", rfDut[9], r9Saved);

        // Full scrub against continuous non-secure writes to r0 (which the file never stores).
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h55AA55AA, 1'b1);
        lowCnt = 0; scrubWrites = 0; lastAddr = -1; lastIdx = -1; doneIdx = -1; doneCnt = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 32'h55AA55AA, 1'b0);
            if (!wbReady) lowCnt++;
            if (rfWe && rfFirst) begin scrubWrites++; lastAddr = int'(rfWaddr); lastIdx = i; end
            if (scrubDone) begin doneCnt++; doneIdx = i; break; end
        end
        checkOutput("scrub_done_seen", 32'(doneCnt), 32'd1);
        checkOutput("scrub_ready_low", 32'(lowCnt), 32'd32);
        checkOutput("scrub_writes", 32'(scrubWrites), 32'd31);
        checkOutput("scrub_last_addr", 32'(lastAddr), 32'd31);
        checkOutput("scrub_done_lat", 32'(doneIdx), 32'(lastIdx + 1));
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        diffs = 0;
        for (int i = 1; i < NUM; i++) if (rfDut[i] !== 32'h0) diffs++;
        checkOutput("scrub_all_zero", 32'(diffs), 32'd0);

        applyStimulus(1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0BADCAFE, 1'b1);
        checkOutput("mix_busy_no_comb", 32'(scrubBusy), 32'd0);
        checkOutput("mix_first", 32'(rfFirst), 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0BADCAFE, 1'b0);
        checkOutput("mix_ready", 32'(wbReady), 32'd1);
        checkOutput("mix_busy", 32'(scrubBusy), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("mix_r3_data", rfDut[3], 32'h0BADCAFE);
        checkOutput("mix_pend_ready", 32'(wbReady), 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'(i == 10));
            if (scrubDone) doneCnt++;
        end
        checkOutput("mix_one_done", 32'(doneCnt), 32'd1);
        checkOutput("mix_r3_zero", rfDut[3], 32'h0);

        for (int i = 1; i < NUM; i++) begin
            d = $urandom | 32'h1;
            saved[i] = d;
            applyStimulus(1'b1, 1'b0, 5'(i), d, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
            if (rfWe && rfFirst && rfWaddr == 5'd10) begin found = 1'b1; break; end
        end
        checkOutput("rst_reach_a10", 32'(found), 32'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(scrubBusy), 32'd0);
        checkOutput("rst_done", 32'(scrubDone), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        rstN = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
            if (scrubDone) doneCnt++;
        end
        checkOutput("rst_no_done", 32'(doneCnt), 32'd0);
        diffs = 0;
        for (int i = 11; i < NUM; i++) if (rfDut[i] !== saved[i]) diffs++;
        checkOutput("rst_upper_kept", 32'(diffs), 32'd0);
        diffs = 0;
        for (int i = 1; i < 10; i++) if (rfDut[i] !== 32'h0) diffs++;
        checkOutput("rst_lower_zero", 32'(diffs), 32'd0);

        // Random traffic: hold a stalled request, with occasional deliberate protocol violations.
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            violate = ($urandom_range(15) == 0);
            if (hold && !violate)
                applyStimulus(wbReq, wbSecure, wbAddr, wbWdata, 1'($urandom_range(39) == 0));
            else if (hold && $urandom_range(1) == 0)
                applyStimulus(1'b0, wbSecure, wbAddr, wbWdata, 1'b0);
            else
                applyStimulus(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 5'($urandom_range(31)),
                              $urandom, 1'($urandom_range(39) == 0));
            hold = wbReq && !wbReady;
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int i = 1; i < NUM; i++) checkOutput($sformatf("rf_r%0d", i), rfDut[i], rfModel[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
